// File: rtl/canon_huff_builder.sv
// canon_huff_builder: canonical Huffman code builder (length scan, validation, record stream).
// Optional macro CANON_HUFF_BITREV_EN: emit codes bit-reversed within their length (LSB-first).
`default_nettype none

module canon_huff_builder #(
  parameter int NUM_SYMS = 288,
  parameter int SYM_BIT  = 9,
  parameter int LEN_BIT  = 4,
  parameter int MAX_LEN  = 15
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [SYM_BIT:0]   num_syms,
  output logic [SYM_BIT-1:0] len_addr,
  output logic               len_ena,
  input  logic [LEN_BIT-1:0] len_data,
  output logic               code_valid,
  input  logic               code_ready,
  output logic [SYM_BIT-1:0] code_sym,
  output logic [MAX_LEN-1:0] code_val,
  output logic [LEN_BIT-1:0] code_len,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [1:0]         err_code
);

  localparam int CW = SYM_BIT + 1;
  localparam int SW = MAX_LEN + 2;
  localparam int LW = $clog2(MAX_LEN + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_COUNT  = 3'd1,
    S_CHECK  = 3'd2,
    S_ASSIGN = 3'd3,
    S_DONE   = 3'd4,
    S_FAIL   = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        nsyms_q, nsyms_d;
  logic [CW-1:0]        addr_q, addr_d;
  logic [CW-1:0]        nz_q, nz_d;
  logic                 flag_q, flag_d;
  logic [1:0]           err_q, err_d;
  logic [LW-1:0]        l_q, l_d;
  logic signed [SW-1:0] left_q, left_d;
  logic                 rd_vld_q, rd_vld_d;
  logic [SYM_BIT-1:0]   rd_sym_q, rd_sym_d;
  logic                 rec_valid_q, rec_valid_d;
  logic [SYM_BIT-1:0]   rec_sym_q, rec_sym_d;
  logic [LEN_BIT-1:0]   rec_len_q, rec_len_d;
  logic [MAX_LEN-1:0]   rec_code_q, rec_code_d;
  logic [CW-1:0]        bl_count_q [0:MAX_LEN];
  logic [CW-1:0]        bl_count_d [0:MAX_LEN];
  logic [MAX_LEN-1:0]   next_code_q [0:MAX_LEN];
  logic [MAX_LEN-1:0]   next_code_d [0:MAX_LEN];

  logic                 len_bad;
  logic [LW-1:0]        l_m1;
  logic [MAX_LEN-1:0]   nc_step;
  logic signed [SW-1:0] left_nx;
  logic                 hs;
  logic                 load_rec;

  // Lengths wider than the legal range can only occur when LEN_BIT can encode them.
  generate
    if (((1 << LEN_BIT) - 1) > MAX_LEN) begin : g_len_chk
      assign len_bad = (int'(len_data) > MAX_LEN);
    end else begin : g_len_ok
      assign len_bad = 1'b0;
    end
  endgenerate

`ifdef CANON_HUFF_BITREV_EN
  function automatic logic [MAX_LEN-1:0] f_rev(input logic [MAX_LEN-1:0] c,
                                               input logic [LEN_BIT-1:0] n);
    logic [MAX_LEN-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (i < int'(n)) r[i] = c[int'(n) - 1 - i];
    end
    return r;
  endfunction
`endif

  assign l_m1     = l_q - 1'b1;
  assign nc_step  = (next_code_q[l_m1] + MAX_LEN'(bl_count_q[l_m1])) << 1;
  assign left_nx  = (left_q <<< 1) - $signed(SW'(bl_count_q[l_q]));
  assign hs       = rec_valid_q && code_ready;
  assign load_rec = rd_vld_q && (len_data != '0);

  always_comb begin
    state_d     = state_q;
    nsyms_d     = nsyms_q;
    addr_d      = addr_q;
    nz_d        = nz_q;
    flag_d      = flag_q;
    err_d       = err_q;
    l_d         = l_q;
    left_d      = left_q;
    rd_vld_d    = 1'b0;
    rd_sym_d    = rd_sym_q;
    rec_valid_d = rec_valid_q;
    rec_sym_d   = rec_sym_q;
    rec_len_d   = rec_len_q;
    rec_code_d  = rec_code_q;
    bl_count_d  = bl_count_q;
    next_code_d = next_code_q;
    len_ena     = 1'b0;
    len_addr    = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          nsyms_d = num_syms;
          addr_d  = '0;
          nz_d    = '0;
          flag_d  = 1'b0;
          err_d   = 2'b00;
          for (int i = 0; i <= MAX_LEN; i++) begin
            bl_count_d[i]  = '0;
            next_code_d[i] = '0;
          end
          if ((num_syms == '0) || (int'(num_syms) > NUM_SYMS)) begin
            err_d   = 2'b11;
            state_d = S_FAIL;
          end else begin
            state_d = S_COUNT;
          end
        end
      end

      S_COUNT: begin
        if (addr_q < nsyms_q) begin
          len_ena  = 1'b1;
          len_addr = addr_q[SYM_BIT-1:0];
          addr_d   = addr_q + 1'b1;
          rd_vld_d = 1'b1;
        end
        if (rd_vld_q) begin
          if (len_bad) begin
            flag_d = 1'b1;
          end else if (len_data != '0) begin
            bl_count_d[len_data] = bl_count_q[len_data] + 1'b1;
            nz_d                 = nz_q + 1'b1;
          end
          // The read for the last symbol returns one cycle after the final address.
          if (addr_q == nsyms_q) begin
            if (flag_d) begin
              err_d   = 2'b11;
              state_d = S_FAIL;
            end else begin
              l_d     = LW'(1);
              left_d  = SW'(1);
              state_d = S_CHECK;
            end
          end
        end
      end

      S_CHECK: begin
        next_code_d[l_q] = nc_step;
        left_d           = left_nx;
        l_d              = l_q + 1'b1;
        if (left_nx[SW-1]) begin
          err_d   = 2'b01;
          state_d = S_FAIL;
        end else if (l_q == LW'(MAX_LEN)) begin
          if ((left_nx != '0) && (nz_q > CW'(1))) begin
            err_d   = 2'b10;
            state_d = S_FAIL;
          end else begin
            addr_d      = '0;
            rec_valid_d = 1'b0;
            state_d     = S_ASSIGN;
          end
        end
      end

      S_ASSIGN: begin
        if (hs) begin
          next_code_d[rec_len_q] = next_code_q[rec_len_q] + 1'b1;
          rec_valid_d            = 1'b0;
        end
        if (load_rec) begin
          rec_valid_d = 1'b1;
          rec_sym_d   = rd_sym_q;
          rec_len_d   = len_data;
`ifdef CANON_HUFF_BITREV_EN
          rec_code_d  = f_rev(next_code_q[len_data], len_data);
`else
          rec_code_d  = next_code_q[len_data];
`endif
        end else if ((addr_q < nsyms_q) && (!rec_valid_q || code_ready)) begin
          len_ena  = 1'b1;
          len_addr = addr_q[SYM_BIT-1:0];
          addr_d   = addr_q + 1'b1;
          rd_vld_d = 1'b1;
          rd_sym_d = addr_q[SYM_BIT-1:0];
        end else if ((addr_q == nsyms_q) && !rd_vld_q && !rec_valid_q) begin
          state_d = S_DONE;
        end
      end

      S_DONE:  state_d = S_IDLE;
      S_FAIL:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      nsyms_q     <= '0;
      addr_q      <= '0;
      nz_q        <= '0;
      flag_q      <= 1'b0;
      err_q       <= 2'b00;
      l_q         <= '0;
      left_q      <= '0;
      rd_vld_q    <= 1'b0;
      rd_sym_q    <= '0;
      rec_valid_q <= 1'b0;
      rec_sym_q   <= '0;
      rec_len_q   <= '0;
      rec_code_q  <= '0;
      for (int i = 0; i <= MAX_LEN; i++) begin
        bl_count_q[i]  <= '0;
        next_code_q[i] <= '0;
      end
    end else begin
      nsyms_q     <= nsyms_d;
      addr_q      <= addr_d;
      nz_q        <= nz_d;
      flag_q      <= flag_d;
      err_q       <= err_d;
      l_q         <= l_d;
      left_q      <= left_d;
      rd_vld_q    <= rd_vld_d;
      rd_sym_q    <= rd_sym_d;
      rec_valid_q <= rec_valid_d;
      rec_sym_q   <= rec_sym_d;
      rec_len_q   <= rec_len_d;
      rec_code_q  <= rec_code_d;
      bl_count_q  <= bl_count_d;
      next_code_q <= next_code_d;
    end
  end

  assign code_valid = rec_valid_q;
  assign code_sym   = rec_sym_q;
  assign code_val   = rec_code_q;
  assign code_len   = rec_len_q;
  assign busy       = (state_q == S_COUNT) || (state_q == S_CHECK) || (state_q == S_ASSIGN);
  assign done       = (state_q == S_DONE) || (state_q == S_FAIL);
  assign error      = (state_q == S_FAIL);
  assign err_code   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_canon_huff_builder.sv
// tb_canon_huff_builder: scoreboard bench for canon_huff_builder with a registered length RAM model.
`default_nettype none

module tb_canon_huff_builder;

  localparam int NS = 288;
  localparam int SB = 9;
  localparam int LB = 4;
  localparam int ML = 15;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [SB:0]   num_syms = '0;
  logic [SB-1:0] len_addr;
  logic          len_ena;
  logic [LB-1:0] len_data = '0;
  logic          code_valid;
  logic          code_ready = 1'b1;
  logic [SB-1:0] code_sym;
  logic [ML-1:0] code_val;
  logic [LB-1:0] code_len;
  logic          busy;
  logic          done;
  logic          error;
  logic [1:0]    err_code;

  canon_huff_builder #(.NUM_SYMS(NS), .SYM_BIT(SB), .LEN_BIT(LB), .MAX_LEN(ML)) dut (
    .clock(clock), .reset(reset), .start(start), .num_syms(num_syms),
    .len_addr(len_addr), .len_ena(len_ena), .len_data(len_data),
    .code_valid(code_valid), .code_ready(code_ready), .code_sym(code_sym),
    .code_val(code_val), .code_len(code_len), .busy(busy), .done(done),
    .error(error), .err_code(err_code)
  );

  always #5 clock = ~clock;

  logic [LB-1:0] mem [0:NS-1];
  always @(posedge clock) if (len_ena) len_data <= mem[len_addr];

  typedef struct packed {
    logic [SB-1:0] sym;
    logic [ML-1:0] val;
    logic [LB-1:0] len;
  } rec_t;

  rec_t q[$];
  int   total = 0;
  int   bad = 0;
  int   recs = 0;
  int   valids = 0;
  bit   bp = 1'b0;
  bit   fixed_mode = 1'b0;
  bit   prev_stall = 1'b0;
  rec_t prev_rec;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [ML-1:0] rev(input logic [ML-1:0] c, input int n);
    logic [ML-1:0] r;
    r = '0;
    for (int i = 0; i < n; i++) begin
`ifdef CANON_HUFF_BITREV_EN
      r[i] = c[n-1-i];
`else
      r[i] = c[i];
`endif
    end
    return r;
  endfunction

  task automatic push_rec(input int sym, input int code, input int len);
    rec_t r;
    r.sym = sym[SB-1:0];
    r.val = rev(code[ML-1:0], len);
    r.len = len[LB-1:0];
    q.push_back(r);
  endtask

  // Reference: RFC1951 bl_count / next_code construction straight from the RAM image.
  task automatic model(input int n, output int err, output int nrec);
    int bl [16];
    int nc [16];
    int left;
    int nz;
    bl = '{default: 0};
    nc = '{default: 0};
    nz = 0; err = 0; nrec = 0;
    if (n == 0 || n > NS) begin err = 3; return; end
    for (int i = 0; i < n; i++) if (mem[i] != 0) begin bl[int'(mem[i])]++; nz++; end
    left = 1;
    for (int l = 1; l <= ML; l++) begin
      left = 2 * left - bl[l];
      if (left < 0) begin err = 1; return; end
    end
    if (left > 0 && nz > 1) begin err = 2; return; end
    for (int l = 2; l <= ML; l++) nc[l] = (nc[l-1] + bl[l-1]) << 1;
    for (int i = 0; i < n; i++) begin
      if (mem[i] != 0) begin
        push_rec(i, nc[int'(mem[i])], int'(mem[i]));
        nc[int'(mem[i])]++;
        nrec++;
      end
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < NS; i++) mem[i] = '0;
  endtask

  task automatic load_t1();
    int lens [8] = '{3, 3, 3, 3, 3, 2, 4, 4};
    int codes [8] = '{2, 3, 4, 5, 6, 0, 14, 15};
    clear_mem();
    for (int i = 0; i < 8; i++) begin
      mem[i] = lens[i][LB-1:0];
      push_rec(i, codes[i], lens[i]);
    end
  endtask

  task automatic load_fixed();
    clear_mem();
    for (int i = 0; i < 144; i++) mem[i] = 4'd8;
    for (int i = 144; i < 256; i++) mem[i] = 4'd9;
    for (int i = 256; i < 280; i++) mem[i] = 4'd7;
    for (int i = 280; i < 288; i++) mem[i] = 4'd8;
  endtask

  always @(negedge clock) begin
    rec_t exp_r;
    if (!reset) begin
      if (code_valid) valids++;
      if (prev_stall)
        chk("stall_hold", {code_valid, code_sym, code_val, code_len}, {1'b1, prev_rec});
      if (code_valid && !code_ready) chk("stall_len_ena", len_ena, 1'b0);
      if (code_valid && code_ready) begin
        chk("rec_expected", q.size() != 0, 1'b1);
        if (q.size() != 0) begin
          exp_r = q.pop_front();
          chk("rec", {code_sym, code_val, code_len}, exp_r);
        end
        recs++;
        if (fixed_mode) begin
          case (int'(code_sym))
            0:   chk("fix_sym0",   {code_val, code_len}, {rev(15'h030, 8), 4'd8});
            144: chk("fix_sym144", {code_val, code_len}, {rev(15'h190, 9), 4'd9});
            256: chk("fix_sym256", {code_val, code_len}, {rev(15'h000, 7), 4'd7});
            280: chk("fix_sym280", {code_val, code_len}, {rev(15'h0C0, 8), 4'd8});
            default: ;
          endcase
        end
      end
      prev_stall = code_valid && !code_ready;
      prev_rec   = {code_sym, code_val, code_len};
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    forever begin
      @(posedge clock);
      #1;
      code_ready = bp ? ~code_ready : 1'b1;
    end
  end

  task automatic run(input int n, input int exp_err, input int exp_nrec, output int waited);
    bit got_done;
    recs = 0; valids = 0;
    @(posedge clock); #1;
    num_syms = n[SB:0];
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    waited = 0; got_done = 1'b0;
    while (waited < 4000 && !got_done) begin
      @(negedge clock);
      waited++;
      if (done) got_done = 1'b1;
    end
    chk("done_seen", got_done, 1'b1);
    if (got_done) begin
      chk("error", error, exp_err != 0);
      chk("err_code", err_code, exp_err[1:0]);
      chk("busy_at_done", busy, 1'b0);
      @(negedge clock);
      chk("done_pulse", done, 1'b0);
      chk("err_code_hold", err_code, exp_err[1:0]);
    end
    chk("rec_count", recs, exp_nrec);
    chk("queue_drained", q.size(), 0);
    if (exp_err != 0) chk("no_valid_on_fail", valids, 0);
    q.delete();
  endtask

  initial begin
    int err, nrec, waited, wcnt;
    clear_mem();
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset_outputs", {len_ena, code_valid, busy, done, error, err_code}, 7'd0);
    @(posedge clock); #1;
    reset = 1'b0;

    // RFC1951 example
    load_t1();
    run(8, 0, 8, waited);

    // fixed literal/length tree
    load_fixed();
    model(288, err, nrec);
    chk("model_fixed_count", nrec, 288);
    fixed_mode = 1'b1;
    run(288, 0, 288, waited);
    fixed_mode = 1'b0;

    // oversubscribed
    clear_mem();
    mem[0] = 4'd1; mem[1] = 4'd1; mem[2] = 4'd1;
    run(3, 1, 0, waited);

    // bad counts
    run(0, 3, 0, waited);
    chk("zero_count_latency", waited <= 2, 1'b1);
    run(289, 3, 0, waited);

    // single code among 30 symbols
    clear_mem();
    mem[5] = 4'd1;
    push_rec(5, 0, 1);
    run(30, 0, 1, waited);

    // incomplete two-symbol tree
    clear_mem();
    mem[0] = 4'd2; mem[1] = 4'd2;
    run(2, 2, 0, waited);

    // all-zero tree
    clear_mem();
    run(19, 0, 0, waited);

    // random code-length-tree sized builds checked against the model
    for (int t = 0; t < 3; t++) begin
      clear_mem();
      for (int i = 0; i < 19; i++) mem[i] = 4'($urandom_range(0, 7));
      model(19, err, nrec);
      run(19, err, nrec, waited);
    end

    // backpressure
    load_t1();
    bp = 1'b1;
    run(8, 0, 8, waited);
    bp = 1'b0;

    // reset during ASSIGN of the fixed tree
    load_fixed();
    model(288, err, nrec);
    recs = 0;
    @(posedge clock); #1;
    num_syms = 10'd288; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    wcnt = 0;
    while (wcnt < 4000 && recs < 10) begin
      @(negedge clock);
      wcnt++;
    end
    chk("reached_assign", recs >= 10, 1'b1);
    @(posedge clock); #1;
    reset = 1'b1; start = 1'b1; num_syms = 10'd8;
    @(posedge clock); #1;
    chk("mid_reset_outputs",
        {len_ena, len_addr, code_valid, code_sym, code_val, code_len, busy, done, error, err_code},
        44'd0);
    start = 1'b0; reset = 1'b0;
    q.delete();
    @(posedge clock); #1;
    chk("start_with_reset_ignored", busy, 1'b0);

    load_t1();
    run(8, 0, 8, waited);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/canon_huff_builder.md
Name: canon_huff_builder

Overview:
Parametrised canonical Huffman code builder for the DEFLATE decompressor. It serves code-length, literal/length and distance trees from one design.
- Reads per-symbol code lengths from an external length RAM.
- Computes bl_count and next_code, and validates the code (oversubscribed or incomplete).
- Streams one (symbol, code, length) record per non-zero-length symbol over a valid/ready interface to the decode-table writer.
- Single FSM with a start/done handshake and a run-time symbol count (HCLEN/HLIT/HDIST).

Parameters:
NUM_SYMS, 288, maximum symbol count supported (19 / 30 / 288 typical)
SYM_BIT, 9, symbol index width; must be at least clog2(NUM_SYMS)
LEN_BIT, 4, stored code-length width
MAX_LEN, 15, maximum legal code length; CODE_BIT = MAX_LEN

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; begins a build; ignored unless idle
num_syms  in  SYM_BIT+1  active symbol count, sampled on start
len_addr  out  SYM_BIT  length RAM read address
len_ena  out  1  length RAM read enable; data returns next cycle
len_data  in  LEN_BIT  length RAM read data
code_valid  out  1  record valid
code_ready  in  1  consumer accepts record
code_sym  out  SYM_BIT  symbol index
code_val  out  MAX_LEN  code, right-aligned
code_len  out  LEN_BIT  code length
busy  out  1  high from start until done
done  out  1  one-cycle completion pulse
error  out  1  valid with done; build failed
err_code  out  2  00 ok, 01 oversubscribed, 10 incomplete, 11 bad count/length

Behaviour:
- Interface: one clock, `clock`; `reset` is synchronous and active-high.
- Reset, including mid-operation: state returns to IDLE. All outputs, bl_count[] and next_code[] are 0 on the following cycle. A start in the same cycle as reset is ignored.
- States: IDLE, COUNT, CHECK, ASSIGN, DONE, FAIL.
- IDLE:
  - On start, latch num_syms and clear bl_count[0..MAX_LEN] in a single cycle.
  - If num_syms==0 or num_syms>NUM_SYMS, go to FAIL with err 11.
  - Otherwise go to COUNT.
- COUNT:
  - Issue len_addr = 0..num_syms-1, one per cycle, with len_ena=1.
  - Each returned len_data (one cycle later) increments bl_count[len] when non-zero.
  - A length greater than MAX_LEN sets the err 11 flag.
  - Duration is num_syms+1 cycles, then go to CHECK (or FAIL if the flag is set).
- CHECK: one length l per cycle, l = 1..MAX_LEN (MAX_LEN cycles).
  - left = 2*left - bl_count[l], starting from left = 1, as signed MAX_LEN+2-bit arithmetic.
  - next_code[l] = (next_code[l-1] + bl_count[l-1]) << 1, with next_code[1] = 0.
  - If left < 0 at any step, go to FAIL with err 01.
  - At the end, if left > 0 and the total non-zero count is not 0 or 1, go to FAIL with err 10.
  - An all-zero tree or a single code is legal.
  - Otherwise go to ASSIGN.
- ASSIGN:
  - Re-read symbols 0..num_syms-1 in order.
  - A zero-length symbol costs one cycle and produces no record.
  - A non-zero-length symbol presents code_sym/code_val = next_code[len] / code_len with code_valid=1, then increments next_code[len] on the handshake.
  - While code_valid && !code_ready, all record outputs hold stable and len_ena=0.
  - At most one record is in flight.
  - After the last symbol, go to DONE.
- DONE: pulse done=1 with error=0 and err_code=00 for one cycle; busy drops in the same cycle; return to IDLE.
- FAIL: pulse done=1 with error=1 and err_code held for one cycle; no records are emitted; return to IDLE. err_code holds until the next start.
- code_val upper bits above code_len are 0.
- len_ena=0 whenever the RAM is not being read.

Optional Feature:
- Macro: CANON_HUFF_BITREV_EN.
- When defined, code_val carries the code bit-reversed within code_len bits (LSB-first, matching the DEFLATE bitstream order for direct table indexing).
- When undefined, code_val carries the canonical MSB-first code.
- Handshake timing is identical in both builds.

Test Plan:
1. RFC1951 example: num_syms=8, lengths 3,3,3,3,3,2,4,4. Required records, in symbol order: sym0 010, sym1 011, sym2 100, sym3 101, sym4 110, sym5 00, sym6 1110, sym7 1111. done with error=0.
2. Fixed literal/length tree: 288 symbols, lengths 8(0-143), 9(144-255), 7(256-279), 8(280-287). Required: sym0 0x30/8, sym144 0x190/9, sym256 0x00/7, sym280 0xC0/8; exactly 288 records.
3. Lengths 1,1,1 (num_syms=3) -> done, error=1, err_code=01, code_valid never asserted. num_syms=0 -> err 11 within 2 cycles of start.
4. Incomplete trees:
   - num_syms=30, only sym5 length 1 -> one record sym5 code 0 len 1, error=0.
   - lengths 2,2 -> err 10.
   - all zeros -> zero records, error=0.
5. Backpressure: test 1 with code_ready alternating 1/0 -> identical record sequence; outputs stable during stalls; len_ena=0 while stalled.
6. Reset asserted during ASSIGN of test 2 -> all outputs 0 next cycle. A new start with test 1 data completes correctly. With CANON_HUFF_BITREV_EN, sym6 code_val = 0111.
